mem_bus_arbiter: RTL



---
 rtl/mem_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one slave bus between instruction and data masters
module mem_bus_arbiter #(
    parameter logic [31:0] IRAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] IRAM_TOP   = 32'h0004_0000,
    parameter logic [31:0] DRAM_BASE  = 32'h0004_0000,
    parameter logic [31:0] DRAM_TOP   = 32'h0008_0000,
    parameter logic [31:0] TIMER_BASE = 32'h0020_0000,
    parameter logic [31:0] TIMER_TOP  = 32'h0020_0010,
    parameter logic [31:0] UART_BASE  = 32'h0010_0000,
    parameter logic [31:0] UART_TOP   = 32'h0010_0004,
    parameter int          TIMEOUT    = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         imemory_valid,
    input  logic         imemory_instr,
    input  logic [31:0]  imemory_addr,
    input  logic [31:0]  imemory_wdata,
    input  logic [3:0]   imemory_wstrb,
    output logic [31:0]  imemory_rdata,
    output logic         imemory_ready,
    output logic         imemory_error,
    input  logic         dmemory_valid,
    input  logic         dmemory_instr,
    input  logic [31:0]  dmemory_addr,
    input  logic [31:0]  dmemory_wdata,
    input  logic [3:0]   dmemory_wstrb,
    output logic [31:0]  dmemory_rdata,
    output logic         dmemory_ready,
    output logic         dmemory_error,
    output logic [3:0]   slv_valid,
    output logic         slv_instr,
    output logic [31:0]  slv_addr,
    output logic [31:0]  slv_wdata,
    output logic [3:0]   slv_wstrb,
    input  logic [127:0] slv_rdata,
    input  logic [3:0]   slv_ready
);

    localparam int CW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t state, state_nxt;

    // Per-master pending request and its latched fields
    logic        pend_i, pend_d;
    logic        i_instr_q, d_instr_q;
    logic [31:0] i_addr_q, d_addr_q, i_wdata_q, d_wdata_q;
    logic [3:0]  i_wstrb_q, d_wstrb_q;

    logic        owner;          // 0 = instruction port, 1 = data port
    logic        last_grant;
    logic [1:0]  slave_q;
    logic [CW-1:0] cnt;
    logic [31:0] resp_data;
    logic        resp_err;

    logic        req_i, req_d, any_req, grant_d;
    logic        sel_instr;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        dec_hit;
    logic [1:0]  dec_slv;
    logic [31:0] dec_off;
    logic        ready_own;
    logic [31:0] lane_data;

    // Effective request: live pulse when nothing is pending, latched copy otherwise
    always_comb begin
        req_i   = pend_i | imemory_valid;
        req_d   = pend_d | dmemory_valid;
        any_req = req_i | req_d;
        grant_d = req_d & (~req_i | ~last_grant);
        if (grant_d) begin
            sel_instr = pend_d ? d_instr_q : dmemory_instr;
            sel_addr  = pend_d ? d_addr_q  : dmemory_addr;
            sel_wdata = pend_d ? d_wdata_q : dmemory_wdata;
            sel_wstrb = pend_d ? d_wstrb_q : dmemory_wstrb;
        end else begin
            sel_instr = pend_i ? i_instr_q : imemory_instr;
            sel_addr  = pend_i ? i_addr_q  : imemory_addr;
            sel_wdata = pend_i ? i_wdata_q : imemory_wdata;
            sel_wstrb = pend_i ? i_wstrb_q : imemory_wstrb;
        end
    end

    // Offset-below-span test covers base <= addr < top in one unsigned compare
    always_comb begin
        dec_hit = 1'b0;
        dec_slv = 2'd0;
        dec_off = 32'd0;
        if ((sel_addr - IRAM_BASE) < (IRAM_TOP - IRAM_BASE)) begin
            dec_hit = 1'b1;
            dec_slv = 2'd0;
            dec_off = sel_addr - IRAM_BASE;
        end else if ((sel_addr - DRAM_BASE) < (DRAM_TOP - DRAM_BASE)) begin
            dec_hit = 1'b1;
            dec_slv = 2'd1;
            dec_off = sel_addr - DRAM_BASE;
        end else if ((sel_addr - TIMER_BASE) < (TIMER_TOP - TIMER_BASE)) begin
            dec_hit = 1'b1;
            dec_slv = 2'd2;
            dec_off = sel_addr - TIMER_BASE;
        end else if ((sel_addr - UART_BASE) < (UART_TOP - UART_BASE)) begin
            dec_hit = 1'b1;
            dec_slv = 2'd3;
            dec_off = sel_addr - UART_BASE;
        end
    end

    assign ready_own = slv_ready[slave_q];
    assign lane_data = slv_rdata[{slave_q, 5'b0} +: 32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = dec_hit ? S_ISSUE : S_RESP;
            S_ISSUE: state_nxt = ready_own ? S_RESP : S_WAIT;
            S_WAIT:  if (ready_own || cnt == CNT_LAST) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_i     <= 1'b0;
            pend_d     <= 1'b0;
            i_instr_q  <= 1'b0;
            i_addr_q   <= 32'd0;
            i_wdata_q  <= 32'd0;
            i_wstrb_q  <= 4'd0;
            d_instr_q  <= 1'b0;
            d_addr_q   <= 32'd0;
            d_wdata_q  <= 32'd0;
            d_wstrb_q  <= 4'd0;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            slave_q    <= 2'd0;
            cnt        <= '0;
            resp_data  <= 32'd0;
            resp_err   <= 1'b0;
            slv_instr  <= 1'b0;
            slv_addr   <= 32'd0;
            slv_wdata  <= 32'd0;
            slv_wstrb  <= 4'd0;
        end else begin
            // The owner may queue its next request in its own response cycle
            if (state == S_RESP && !owner) begin
                pend_i <= imemory_valid;
            end else if (imemory_valid && !pend_i) begin
                pend_i <= 1'b1;
            end
            if ((state == S_RESP && !owner) || !pend_i) begin
                if (imemory_valid) begin
                    i_instr_q <= imemory_instr;
                    i_addr_q  <= imemory_addr;
                    i_wdata_q <= imemory_wdata;
                    i_wstrb_q <= imemory_wstrb;
                end
            end
            if (state == S_RESP && owner) begin
                pend_d <= dmemory_valid;
            end else if (dmemory_valid && !pend_d) begin
                pend_d <= 1'b1;
            end
            if ((state == S_RESP && owner) || !pend_d) begin
                if (dmemory_valid) begin
                    d_instr_q <= dmemory_instr;
                    d_addr_q  <= dmemory_addr;
                    d_wdata_q <= dmemory_wdata;
                    d_wstrb_q <= dmemory_wstrb;
                end
            end

            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner <= grant_d;
                        if (dec_hit) begin
                            slave_q   <= dec_slv;
                            slv_instr <= sel_instr;
                            slv_addr  <= dec_off;
                            slv_wdata <= sel_wdata;
                            slv_wstrb <= sel_wstrb;
                        end else begin
                            resp_data <= 32'd0;
                            resp_err  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                    if (ready_own) begin
                        resp_data <= lane_data;
                        resp_err  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (ready_own) begin
                        resp_data <= lane_data;
                        resp_err  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        resp_data <= 32'd0;
                        resp_err  <= 1'b1;
                    end
                end
                S_RESP: begin
                    last_grant <= owner;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        slv_valid     = 4'd0;
        imemory_ready = 1'b0;
        imemory_rdata = 32'd0;
        imemory_error = 1'b0;
        dmemory_ready = 1'b0;
        dmemory_rdata = 32'd0;
        dmemory_error = 1'b0;
        if (state == S_ISSUE) begin
            slv_valid = 4'b0001 << slave_q;
        end
        if (state == S_RESP) begin
            if (owner) begin
                dmemory_ready = 1'b1;
                dmemory_rdata = resp_data;
                dmemory_error = resp_err;
            end else begin
                imemory_ready = 1'b1;
                imemory_rdata = resp_data;
                imemory_error = resp_err;
            end
        end
    end

endmodule
